// File: rtl/key_conditioner.sv
// Debounces one raw active-low pushbutton into a level and a single-cycle press pulse.
// Optional saturating press counter enabled by defining KEY_CONDITIONER_PRESS_COUNT_EN.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       KEY_N,
  output logic       ENTER_PULSE,
  output logic       LEVEL,
  output logic [1:0] STATE,
  output logic [7:0] PRESS_COUNT
);

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ks1_q, ks2_q;
  logic             pulse_q, pulse_d;
  logic             pressed;
  logic             cnt_last;

  assign pressed  = ~ks2_q;
  assign cnt_last = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (RESET) begin
      ks1_q   <= 1'b1;
      ks2_q   <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      ks1_q   <= KEY_N;
      ks2_q   <= ks1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
        end else if (cnt_last) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce during release returns to PRESSED without a fresh pulse
        if (pressed) begin
          state_d = PRESSED;
        end else if (cnt_last) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign ENTER_PULSE = pulse_q;
  assign LEVEL       = (state_q == PRESSED) | (state_q == RELEASE_WAIT);
  assign STATE       = state_q;

`ifdef KEY_CONDITIONER_PRESS_COUNT_EN
  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (pulse_q && (count_q != 8'hFF)) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (RESET) count_q <= 8'h00;
    else       count_q <= count_d;
  end

  assign PRESS_COUNT = count_q;
`else
  assign PRESS_COUNT = 8'h00;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus random key activity,
// every cycle compared against a run-length debounce model.
module tb_key_conditioner;

  localparam int D = 4;

  logic       clk;
  logic       RESET;
  logic       KEY_N;
  logic       ENTER_PULSE;
  logic       LEVEL;
  logic [1:0] STATE;
  logic [7:0] PRESS_COUNT;

  int checks = 0;
  int errors = 0;

  // Model: the debounced level flips once the synchronized key has disagreed with it
  // for D+1 consecutive sampled edges; any agreeing sample restarts the run.
  logic syncQ[$];
  logic mLevel;
  int   mRun;
  logic mPulse;
  int   mCount;

  int   edgeNum;
  int   pulseSeen;
  int   lastPulseEdge;
  int   lastFallEdge;
  logic prevLevel;

  key_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .RESET       (RESET),
    .KEY_N       (KEY_N),
    .ENTER_PULSE (ENTER_PULSE),
    .LEVEL       (LEVEL),
    .STATE       (STATE),
    .PRESS_COUNT (PRESS_COUNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, edgeNum, observed, expected);
    end
  endtask

  task automatic modelStep(input logic rst, input logic keyN);
    logic p;
    logic newPulse;
    if (rst) begin
      syncQ = {1'b1, 1'b1};
      mLevel = 1'b0;
      mRun = 0;
      mPulse = 1'b0;
      mCount = 0;
    end else begin
      p = !syncQ[0];
      void'(syncQ.pop_front());
      syncQ.push_back(keyN);
      newPulse = 1'b0;
      if (p != mLevel) begin
        mRun++;
        if (mRun == D + 1) begin
          mLevel = p;
          mRun = 0;
          newPulse = p;
        end
      end else begin
        mRun = 0;
      end
      if (mPulse && mCount < 255) mCount++;
      mPulse = newPulse;
    end
  endtask

  function automatic logic [1:0] expState();
    if (!mLevel) return (mRun == 0) ? 2'b00 : 2'b01;
    else         return (mRun == 0) ? 2'b10 : 2'b11;
  endfunction

  task automatic applyStimulus(input logic rst, input logic keyN);
    @(negedge clk);
    RESET = rst;
    KEY_N = keyN;
    @(posedge clk);
    edgeNum++;
    modelStep(rst, keyN);
    #1;
    checkOutput("ENTER_PULSE", {31'd0, ENTER_PULSE}, {31'd0, mPulse});
    checkOutput("LEVEL", {31'd0, LEVEL}, {31'd0, mLevel});
    checkOutput("STATE", {30'd0, STATE}, {30'd0, expState()});
`ifdef KEY_CONDITIONER_PRESS_COUNT_EN
    checkOutput("PRESS_COUNT", {24'd0, PRESS_COUNT}, mCount);
`else
    checkOutput("PRESS_COUNT", {24'd0, PRESS_COUNT}, 32'd0);
`endif
    if (ENTER_PULSE === 1'b1) begin
      pulseSeen++;
      lastPulseEdge = edgeNum;
    end
    if (prevLevel === 1'b1 && LEVEL === 1'b0) lastFallEdge = edgeNum;
    prevLevel = LEVEL;
  endtask

  task automatic holdKey(input logic keyN, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, keyN);
  endtask

  initial begin
    int startEdge;
    int hold;
    logic k;
    RESET = 1'b1;
    KEY_N = 1'b1;
    edgeNum = 0;
    pulseSeen = 0;
    lastPulseEdge = -1;
    lastFallEdge = -1;
    prevLevel = 1'b0;

    // Reset check
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("reset_state", {30'd0, STATE}, 32'd0);
    checkOutput("reset_level", {31'd0, LEVEL}, 32'd0);
    holdKey(1'b1, 3);

    // Clean press: pulse exactly once, D+2 edges after the first low sample
    pulseSeen = 0;
    startEdge = edgeNum + 1;
    holdKey(1'b0, 20);
    checkOutput("clean_pulses", pulseSeen, 32'd1);
    checkOutput("clean_latency", lastPulseEdge - startEdge, D + 2);
    checkOutput("clean_state", {30'd0, STATE}, 32'h2);

    // Release bounce: one fall, D+2 edges after the final rise
    pulseSeen = 0;
    holdKey(1'b1, 2);
    holdKey(1'b0, 1);
    startEdge = edgeNum + 1;
    holdKey(1'b1, 10);
    checkOutput("relbounce_pulses", pulseSeen, 32'd0);
    checkOutput("relbounce_fall", lastFallEdge - startEdge, D + 2);
    checkOutput("relbounce_level", {31'd0, LEVEL}, 32'd0);

    // Press bounce: two short low runs never qualify
    pulseSeen = 0;
    holdKey(1'b0, 3);
    holdKey(1'b1, 1);
    holdKey(1'b0, 3);
    holdKey(1'b1, 8);
    checkOutput("bounce_pulses", pulseSeen, 32'd0);
    checkOutput("bounce_state", {30'd0, STATE}, 32'h0);

    // Reset mid-hold: re-debounced from IDLE, one new pulse
    holdKey(1'b0, 12);
    checkOutput("midhold_pre_state", {30'd0, STATE}, 32'h2);
    pulseSeen = 0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("midhold_reset_state", {30'd0, STATE}, 32'h0);
    startEdge = edgeNum + 1;
    holdKey(1'b0, 15);
    checkOutput("midhold_pulses", pulseSeen, 32'd1);
    checkOutput("midhold_latency", lastPulseEdge - startEdge, D + 2);
    holdKey(1'b1, 10);

    // Random key activity with occasional resets
    for (int s = 0; s < 120; s++) begin
      k = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 9);
      if ($urandom_range(0, 15) == 0) applyStimulus(1'b1, k);
      holdKey(k, hold);
    end

    // Counter saturation over 300 clean presses
    applyStimulus(1'b1, 1'b1);
    holdKey(1'b1, 2);
    pulseSeen = 0;
    for (int n = 0; n < 300; n++) begin
      holdKey(1'b0, D + 4);
      holdKey(1'b1, D + 4);
    end
    checkOutput("sat_pulses", pulseSeen, 32'd300);
`ifdef KEY_CONDITIONER_PRESS_COUNT_EN
    checkOutput("sat_count", {24'd0, PRESS_COUNT}, 32'hFF);
`else
    checkOutput("sat_count", {24'd0, PRESS_COUNT}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
